// File: rtl/byte_fifo_buffer_pkg.sv
// Shared constants and types for the byte FIFO between COM_to_FIFO and FIFO_to_out.
package fifo_pkg;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 512;
  localparam int CNT_W  = 10;
  localparam int PTR_W  = $clog2(DEPTH);

  // The only control state: one busy cycle after each accepted request.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } busyState_t;

endpackage

// File: rtl/byte_fifo_buffer_if.sv
// Request/status bundle of the byte FIFO.
// Handshake: a requester pulses we or re for one cycle only while isBusy=0;
// a pulse seen while isBusy=1 (or on a full/empty FIFO) is dropped, never queued.
interface byte_fifo_buffer_if;
  import fifo_pkg::*;

  logic [DATA_W-1:0] dataIn;
  logic              we;
  logic              re;
  logic [DATA_W-1:0] dataOut;
  logic [CNT_W-1:0]  count;
  logic              isEmpty;
  logic              isFull;
  logic              isBusy;
  busyState_t        dbgState;

  modport master (
    output dataIn, we, re,
    input  dataOut, count, isEmpty, isFull, isBusy, dbgState
  );

  modport slave (
    input  dataIn, we, re,
    output dataOut, count, isEmpty, isFull, isBusy, dbgState
  );
endinterface

// File: rtl/byte_fifo_buffer_ram.sv
// Simple dual-port synchronous RAM; the read port register is the FIFO's dataOut.
module fifo_ram
  import fifo_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: storage is never cleared by reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port: holds its value until the next read.
  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/byte_fifo_buffer.sv
// Byte FIFO with registered occupancy/flags and a one-cycle busy lockout after every accepted request.
module byte_fifo_buffer
  import fifo_pkg::*;
(
  input  logic clk,
  input  logic reset,
  byte_fifo_buffer_if.slave bus
);

  logic [PTR_W-1:0] wPtr;
  logic [PTR_W-1:0] rPtr;
  logic [CNT_W-1:0] cntQ;
  logic [CNT_W-1:0] cntNext;
  logic             emptyQ;
  logic             fullQ;
  logic             wrOk;
  logic             rdOk;
  busyState_t       state;
  busyState_t       stateNext;

  // Acceptance: a full FIFO refuses writes and an empty one refuses reads, so a
  // simultaneous request on a boundary degrades to the single legal operation.
  always_comb begin
    wrOk = bus.we && (state == IDLE) && !fullQ;
    rdOk = bus.re && (state == IDLE) && !emptyQ;
  end

  // Next occupancy: a paired read+write leaves the count unchanged.
  always_comb begin
    cntNext = cntQ;
    case ({wrOk, rdOk})
      2'b10:   cntNext = cntQ + CNT_W'(1);
      2'b01:   cntNext = cntQ - CNT_W'(1);
      default: cntNext = cntQ;
    endcase
  end

  // Busy state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Busy next-state: one BUSY cycle after any accepted request.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (wrOk || rdOk) stateNext = BUSY;
      BUSY:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Pointers, count and flags; flags are registered from the next count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wPtr   <= '0;
      rPtr   <= '0;
      cntQ   <= '0;
      emptyQ <= 1'b1;
      fullQ  <= 1'b0;
    end else begin
      if (wrOk) wPtr <= wPtr + PTR_W'(1);
      if (rdOk) rPtr <= rPtr + PTR_W'(1);
      cntQ   <= cntNext;
      emptyQ <= (cntNext == '0);
      fullQ  <= (cntNext == CNT_W'(DEPTH));
    end
  end

  fifo_ram uRam (
    .clk   (clk),
    .reset (reset),
    .we    (wrOk && !reset),
    .waddr (wPtr),
    .wdata (bus.dataIn),
    .re    (rdOk && !reset),
    .raddr (rPtr),
    .rdata (bus.dataOut)
  );

  assign bus.count    = cntQ;
  assign bus.isEmpty  = emptyQ;
  assign bus.isFull   = fullQ;
  assign bus.isBusy   = (state == BUSY);
  assign bus.dbgState = state;

endmodule

// File: tb/tb_byte_fifo_buffer.sv
// Self-checking bench for byte_fifo_buffer: scoreboard queue of expected read bytes.
module tb_byte_fifo_buffer;
  import fifo_pkg::*;

  logic clk;
  logic reset;

  byte_fifo_buffer_if bus ();

  byte_fifo_buffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] exp_q[$];
  int                modelCount;
  logic [DATA_W-1:0] lastOut;
  int                vecCnt;
  int                errCnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vecCnt++;
    if (obs !== expv) begin
      errCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic checkFlags(input string tag);
    check({tag, ".count"}, 32'(bus.count), 32'(modelCount));
    check({tag, ".empty"}, 32'(bus.isEmpty), 32'(modelCount == 0));
    check({tag, ".full"},  32'(bus.isFull), 32'(modelCount == DEPTH));
  endtask

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic waitIdle();
    int n;
    n = 0;
    while (bus.isBusy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.isBusy) check("idle_timeout", 32'(bus.isBusy), 32'd0);
  endtask

  task automatic doWrite(input logic [DATA_W-1:0] d);
    logic acc;
    waitIdle();
    bus.dataIn = d;
    bus.we     = 1'b1;
    @(posedge clk); #1;
    bus.we = 1'b0;
    acc = (modelCount < DEPTH);
    if (acc) begin
      exp_q.push_back(d);
      modelCount++;
    end
    check("wr.busy", 32'(bus.isBusy), 32'(acc));
    checkFlags("wr");
  endtask

  task automatic doRead();
    logic [DATA_W-1:0] e;
    waitIdle();
    bus.re = 1'b1;
    @(posedge clk); #1;
    bus.re = 1'b0;
    if (modelCount > 0) begin
      e = exp_q.pop_front();
      modelCount--;
      lastOut = e;
      check("rd.data", 32'(bus.dataOut), 32'(e));
      check("rd.busy", 32'(bus.isBusy), 32'd1);
    end else begin
      check("rd_empty.data", 32'(bus.dataOut), 32'(lastOut));
      check("rd_empty.busy", 32'(bus.isBusy), 32'd0);
    end
    checkFlags("rd");
  endtask

  task automatic applyReset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    modelCount = 0;
    lastOut    = '0;
  endtask

  initial begin
    vecCnt     = 0;
    errCnt     = 0;
    modelCount = 0;
    lastOut    = '0;
    bus.dataIn = '0;
    bus.we     = 1'b0;
    bus.re     = 1'b0;

    // Reset state
    applyReset(2);
    check("rst.busy", 32'(bus.isBusy), 32'd0);
    check("rst.data", 32'(bus.dataOut), 32'd0);
    checkFlags("rst");

    // Basic order
    doWrite(8'h41);
    doWrite(8'h42);
    doWrite(8'h43);
    repeat (3) doRead();

    // Read on empty is dropped
    doRead();

    // Busy drop: second pulse on the very next cycle is ignored
    waitIdle();
    bus.dataIn = 8'h10;
    bus.we     = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(8'h10);
    modelCount++;
    check("drop.busy1", 32'(bus.isBusy), 32'd1);
    bus.dataIn = 8'h11;
    @(posedge clk); #1;
    bus.we = 1'b0;
    check("drop.busy2", 32'(bus.isBusy), 32'd0);
    checkFlags("drop");
    doRead();

    // Fill to full, overflow attempt, drain, then wrap
    for (int i = 0; i < DEPTH; i++) doWrite(8'(i % 256));
    check("full.flag", 32'(bus.isFull), 32'd1);
    doWrite(8'hFF);
    for (int i = 0; i < DEPTH; i++) doRead();
    check("drain.empty", 32'(bus.isEmpty), 32'd1);
    for (int i = 0; i < 5; i++) doWrite(8'($urandom_range(0, 255)));
    for (int i = 0; i < 5; i++) doRead();

    // Simultaneous read and write with count=2
    doWrite(8'hA0);
    doWrite(8'hA1);
    waitIdle();
    bus.dataIn = 8'hB0;
    bus.we     = 1'b1;
    bus.re     = 1'b1;
    @(posedge clk); #1;
    bus.we = 1'b0;
    bus.re = 1'b0;
    lastOut = exp_q.pop_front();
    exp_q.push_back(8'hB0);
    check("simul.data", 32'(bus.dataOut), 32'(lastOut));
    check("simul.busy", 32'(bus.isBusy), 32'd1);
    checkFlags("simul");
    doRead();
    doRead();

    // Simultaneous on empty: only the write happens
    waitIdle();
    bus.dataIn = 8'hC5;
    bus.we     = 1'b1;
    bus.re     = 1'b1;
    @(posedge clk); #1;
    bus.we = 1'b0;
    bus.re = 1'b0;
    exp_q.push_back(8'hC5);
    modelCount++;
    check("simul_empty.data", 32'(bus.dataOut), 32'(lastOut));
    checkFlags("simul_empty");
    doRead();

    // Reset mid-sequence with count=7 and a write pending
    for (int i = 0; i < 7; i++) doWrite(8'($urandom_range(0, 255)));
    check("mid.count7", 32'(bus.count), 32'd7);
    waitIdle();
    bus.dataIn = 8'h77;
    bus.we     = 1'b1;
    applyReset(1);
    bus.we = 1'b0;
    check("mid.busy", 32'(bus.isBusy), 32'd0);
    check("mid.data", 32'(bus.dataOut), 32'd0);
    checkFlags("mid");
    doWrite(8'h5A);
    doRead();

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/byte_fifo_buffer.md
Name: byte_fifo_buffer

Overview:
- Synchronous byte FIFO between the serial-receive stage (COM_to_FIFO, the writer) and the output-drain stage (FIFO_to_out, the reader) of the UART-to-SD path.
- Stores received bytes and reports occupancy, empty, full and busy status.
- The busy flag is the only back-pressure signal to both requesters.

Parameters:
- DATA_W, 8, data byte width.
- DEPTH, 512, number of storage entries; must be a power of two.
- CNT_W, 10, width of count; must be able to hold the value DEPTH.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- dataIn  input  DATA_W  write data, sampled with we.
- we  input  1  write request, single-cycle pulse.
- re  input  1  read request, single-cycle pulse.
- dataOut  output  DATA_W  registered read data.
- count  output  CNT_W  current number of stored entries.
- isEmpty  output  1  high when count == 0.
- isFull  output  1  high when count == DEPTH.
- isBusy  output  1  high for the one cycle after any accepted request.

Behaviour:
- Reset (sampled on posedge while reset=1):
  - Read and write pointers cleared to 0; count=0.
  - isEmpty=1, isFull=0, isBusy=0, dataOut=0.
  - Storage contents are not cleared.
  - Reset has priority over any request in the same cycle and aborts anything in flight.
- Acceptance, evaluated at posedge N:
  - A write is accepted when we=1, isBusy=0 and not full.
  - A read is accepted when re=1, isBusy=0 and not empty.
  - Requests while isBusy=1 are dropped, not queued; requesters must wait for isBusy=0 before pulsing.
- Accepted write: mem[wptr] <= dataIn at edge N; wptr increments, wrapping modulo DEPTH.
- Accepted read: dataOut <= mem[rptr] at edge N, so data is visible in cycle N+1; rptr increments with wrap. dataOut holds its value until the next accepted read.
- isBusy:
  - Set to 1 at edge N when any request is accepted; cleared at edge N+1.
  - The earliest next acceptance is therefore edge N+2, giving at most one operation per two cycles.
- Simultaneous we and re, both eligible:
  - Both are performed; count is unchanged.
  - When empty, only the write is performed (the read is ignored, count+1).
  - When full, only the read is performed (the write is ignored, count-1).
- count, isEmpty and isFull update at the same edge as the accepted operation and are registered, not combinational from requests.
- Write while full: dropped; no pointer, count or data change; isBusy is not set.
- Read while empty: dropped; dataOut is unchanged; isBusy is not set.
- Pointer wrap-around at DEPTH-1 → 0 is seamless; data order is strictly FIFO.
- The design has no other internal state machine: the sole control state is the busy cycle (IDLE → BUSY → IDLE).

Decomposition:
- Shared package fifo_pkg: constants DATA_W=8, DEPTH=512, CNT_W=10, PTR_W=$clog2(DEPTH).
- One natural sub-module, fifo_ram: simple dual-port synchronous RAM (DEPTH×DATA_W) with write port (we, waddr, wdata) and registered read port (re, raddr, rdata).
- Pointer, count, flag and busy logic stay in the top block.

Test Plan:
- Reset check: assert reset for 2 cycles → count=0, isEmpty=1, isFull=0, isBusy=0, dataOut=0x00.
- Basic order:
  - Write 0x41, 0x42, 0x43, each after isBusy=0 → count=3, isEmpty=0.
  - Read three times → dataOut=0x41, 0x42, 0x43 in the cycle after each read.
  - End state: count=0, isEmpty=1.
- Busy drop: pulse we with 0x10 and again with 0x11 on the very next cycle → second write ignored; count=1; a subsequent read returns 0x10.
- Full and wrap:
  - Write 512 bytes (i mod 256) → isFull=1, count=512.
  - A 513th write of 0xFF is ignored.
  - Read 512 → data 0..255,0..255 in order; isEmpty=1.
  - Write then read 5 more → order preserved across pointer wrap.
- Simultaneous request: with count=2 (0xA0, 0xA1), pulse we=1 (0xB0) and re=1 together → dataOut=0xA0, count stays 2; reading the remainder yields 0xA1, 0xB0.
- Edge cases:
  - re on empty → dataOut unchanged, isBusy=0.
  - Reset asserted mid-sequence with count=7 → next cycle count=0, isEmpty=1, isBusy=0.
